// File: rtl/reg_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_cmd_sequencer_if
// Brief    : Command, response and register-control bundle for the
//            reg_cmd_sequencer. The slave side is the sequencer; the master
//            side is the command source together with the 4-bit register.
// Revision : 1.0  initial release
// ============================================================================
interface reg_cmd_sequencer_if #(
   parameter int W = 4
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;

   logic         reg_clr;
   logic         reg_ld;
   logic         reg_inc;
   logic         reg_shr;
   logic [W-1:0] reg_data;
   logic [W-1:0] reg_q;
   logic         reg_carry;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_op;
   logic [W-1:0] rsp_data;
   logic [W-1:0] rsp_bits;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready, reg_q, reg_carry,
      input  cmd_ready, reg_clr, reg_ld, reg_inc, reg_shr, reg_data,
             rsp_valid, rsp_op, rsp_data, rsp_bits
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready, reg_q, reg_carry,
      output cmd_ready, reg_clr, reg_ld, reg_inc, reg_shr, reg_data,
             rsp_valid, rsp_op, rsp_data, rsp_bits
   );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_cmd_sequencer
// Brief    : Accepts one command per handshake, drives the clr/ld/inc/shr
//            strobes of a W-bit register for the required number of cycles,
//            then returns the final register value and any bits shifted out.
// Revision : 1.0  initial release
// ============================================================================
module reg_cmd_sequencer #(
   parameter int W = 4
) (
   input logic               clk,
   input logic               rst_n,
   reg_cmd_sequencer_if.slave bus
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_EXEC   = 2'd1;
   localparam logic [1:0] c_SETTLE = 2'd2;
   localparam logic [1:0] c_RESP   = 2'd3;

   localparam logic [1:0] c_OP_CLR = 2'b00;
   localparam logic [1:0] c_OP_LD  = 2'b01;
   localparam logic [1:0] c_OP_INC = 2'b10;
   localparam logic [1:0] c_OP_SER = 2'b11;

   localparam logic [W-1:0] c_ONE     = W'(1);
   localparam logic [W-1:0] c_SER_CNT = W'(W);

   logic [1:0]   r_state;
   logic [1:0]   r_op;
   logic [W-1:0] r_data;
   logic [W-1:0] r_cnt;
   logic         r_shr_d;
   logic [1:0]   r_rsp_op;
   logic [W-1:0] r_rsp_data;
   logic [W-1:0] r_rsp_bits;

   logic         w_exec;
   logic         w_shr;

   // Strobes are decoded only from registered state, so each is glitch-free
   // and at most one can be high (they differ in the latched op).
   assign w_exec = (r_state == c_EXEC);
   assign w_shr  = w_exec && (r_op == c_OP_SER);

   assign bus.reg_clr   = w_exec && (r_op == c_OP_CLR);
   assign bus.reg_ld    = w_exec && (r_op == c_OP_LD);
   assign bus.reg_inc   = w_exec && (r_op == c_OP_INC);
   assign bus.reg_shr   = w_shr;
   assign bus.reg_data  = r_data;
   assign bus.cmd_ready = (r_state == c_IDLE);
   assign bus.rsp_valid = (r_state == c_RESP);
   assign bus.rsp_op    = r_rsp_op;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_bits  = r_rsp_bits;

   // Command sequencing FSM with carry collection one cycle behind each shift,
   // since the register's carry is valid only in the cycle after the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_op       <= '0;
         r_data     <= '0;
         r_cnt      <= '0;
         r_shr_d    <= 1'b0;
         r_rsp_op   <= '0;
         r_rsp_data <= '0;
         r_rsp_bits <= '0;
      end else begin
         r_shr_d <= w_shr;
         if (r_shr_d) begin
            r_rsp_bits <= {bus.reg_carry, r_rsp_bits[W-1:1]};
         end
         case (r_state)
            c_IDLE: begin
               if (bus.cmd_valid) begin
                  r_op       <= bus.cmd_op;
                  r_data     <= bus.cmd_data;
                  r_rsp_bits <= '0;
                  case (bus.cmd_op)
                     c_OP_INC: r_cnt <= bus.cmd_data;
                     c_OP_SER: r_cnt <= c_SER_CNT;
                     default:  r_cnt <= c_ONE;
                  endcase
                  // INC 0 has no strobe cycles at all.
                  if ((bus.cmd_op == c_OP_INC) && (bus.cmd_data == '0)) begin
                     r_state <= c_SETTLE;
                  end else begin
                     r_state <= c_EXEC;
                  end
               end
            end
            c_EXEC: begin
               r_cnt <= r_cnt - c_ONE;
               if (r_cnt == c_ONE) begin
                  r_state <= c_SETTLE;
               end
            end
            c_SETTLE: begin
               r_rsp_data <= bus.reg_q;
               r_rsp_op   <= r_op;
               r_state    <= c_RESP;
            end
            default: begin
               if (bus.rsp_ready) begin
                  r_state <= c_IDLE;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/reg_cmd_sequencer.md
# reg_cmd_sequencer

- Command-driven controller directly upstream of the 4-bit clr/ld/inc/shr register.
- Accepts one command per valid/ready handshake and drives the register's clr, ld, inc and shr strobes and its data input for the required number of cycles.
- Samples the register's data output and right-shift carry, then returns one response per command: final register value plus the bits shifted out.
- All register strobes are Moore outputs decoded from registered state, so the register sees glitch-free, one-strobe-per-cycle control.

## Interface
Parameters:
- W, 4, width of the register, cmd_data, reg_data, reg_q, rsp_data and rsp_bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer idle and accepting commands.
- cmd_op  input  2  00 CLR, 01 LOAD, 10 INC, 11 SERIAL.
- cmd_data  input  W  LOAD value, or INC repeat count N; ignored for CLR and SERIAL.
- reg_clr  output  1  clear strobe to the register.
- reg_ld  output  1  load strobe to the register.
- reg_inc  output  1  increment strobe to the register.
- reg_shr  output  1  shift-right strobe to the register.
- reg_data  output  W  load value to the register (latched cmd_data).
- reg_q  input  W  register data output.
- reg_carry  input  1  register right-shift carry output.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_op  output  2  echo of the completed op.
- rsp_data  output  W  reg_q captured at command completion.
- rsp_bits  output  W  carry bits collected by SERIAL, first-shifted bit at bit 0; 0 for other ops.

## Operation
States:
- IDLE: cmd_ready=1.
  - cmd_valid=1 latches op and data into reg_data, clears rsp_bits and loads cnt.
  - cnt = 1 for CLR/LOAD, N for INC, W for SERIAL.
  - Next state is EXEC, or SETTLE directly when op is INC with N=0.
- EXEC: exactly one strobe high per cycle, chosen by the latched op: reg_clr, reg_ld, reg_inc or reg_shr.
  - cnt decrements each cycle.
  - Leaves to SETTLE after the cycle in which cnt=1.
- SETTLE: one cycle, all strobes low.
  - At its closing edge, rsp_data <= reg_q.
- RESP: rsp_valid=1, outputs held stable.
  - rsp_valid && rsp_ready moves to IDLE.

Carry collection:
- shr_d is a register holding the previous cycle's reg_shr.
- On every edge where shr_d=1: rsp_bits <= {reg_carry, rsp_bits[W-1:1]}.
- After W shifts, rsp_bits equals the register value held before SERIAL.

Other rules:
- cmd_ready is 0 in EXEC, SETTLE and RESP; no command is accepted while busy.
- At most one strobe is high in any cycle. All strobes are 0 outside EXEC.
- The register's own wrap-around is not corrected: INC past 15 wraps to 0, and rsp_data reports the wrapped value.
- The sequencer never asserts reg_clr or reg_ld together with reg_inc/reg_shr, so register priority never arbitrates.

## Timing
- Reset (asynchronous, rst_n=0): state IDLE and cmd_ready=1.
  - reg_* strobes, reg_data, rsp_valid, rsp_op, rsp_data, rsp_bits, cnt and shr_d all 0.
  - Takes effect immediately, including mid-command. The register shares rst_n and clears simultaneously.
- Latency, from the accept edge (cycle 0) to the first cycle with rsp_valid=1:
  - CLR and LOAD: cycle 3.
  - INC N: cycle N+2 (INC 0: cycle 2).
  - SERIAL: cycle W+2 (6 for W=4).
- Strobe timing: a strobe is high for the full cycle. The register updates at that cycle's closing edge, and reg_q/reg_carry are valid the following cycle.
- rsp_ready held low keeps the sequencer in RESP indefinitely; outputs stay stable and cmd_ready stays 0.
- Back-to-back: the earliest next accept is the cycle after the rsp handshake edge.
- A cmd_valid arriving while busy must be held by the source until cmd_ready=1.

## Test plan
- Reset mid-SERIAL (assert rst_n=0 in the 2nd EXEC cycle):
  - All strobes drop the same cycle; cmd_ready=1; rsp_valid=0.
  - A following LOAD 0x3 completes normally with rsp_data=0x3.
- LOAD 0xA then CLR, rsp_ready tied 1:
  - reg_ld high exactly 1 cycle, rsp_data=0xA, rsp_valid at cycle 3.
  - CLR gives rsp_data=0x0, rsp_bits=0x0.
- LOAD 0xD, then INC 5:
  - reg_inc high exactly 5 consecutive cycles.
  - rsp_data=0x2 (wrap); rsp_valid at cycle 7.
- INC 0:
  - No strobe ever high; rsp_valid at cycle 2; rsp_data unchanged.
- LOAD 0xB, then SERIAL:
  - reg_shr high exactly 4 cycles; rsp_bits=0xB; rsp_data=0x0; rsp_valid at cycle 6.
- Backpressure: hold rsp_ready=0 for 10 cycles after a LOAD 0x6 response appears:
  - rsp_valid, rsp_op=01 and rsp_data=0x6 stay stable; cmd_ready=0 throughout.
  - A cmd_valid offered during the stall is not accepted.
- Invariant, checked every cycle: reg_clr+reg_ld+reg_inc+reg_shr ≤ 1.
